// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter funnelling NUM_MASTERS bus masters onto one memory bus, grant held until ready_in.
// Optional bus timeout fault enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter_rr #(
    parameter int NUM_MASTERS    = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  ce_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_address_in,
    input  logic [NUM_MASTERS-1:0]                m_read_in,
    input  logic [NUM_MASTERS-1:0]                m_write_in,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   m_write_mask_in,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_write_value_in,
    output logic [DATA_WIDTH-1:0]                 m_read_value_out,
    output logic [NUM_MASTERS-1:0]                m_ready_out,
    output logic [NUM_MASTERS-1:0]                m_fault_out,
    output logic [ADDR_WIDTH-1:0]                 address_out,
    output logic                                  read_out,
    output logic                                  write_out,
    output logic [DATA_WIDTH/8-1:0]               write_mask_out,
    output logic [DATA_WIDTH-1:0]                 write_value_out,
    input  logic [DATA_WIDTH-1:0]                 read_value_in,
    input  logic                                  ready_in,
    input  logic                                  fault_in,
    output logic [NUM_MASTERS-1:0]                grant_out,
    output logic                                  busy_out
);

    localparam int IDX_W  = $clog2(NUM_MASTERS);
    localparam int MASK_W = DATA_WIDTH / 8;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;
    logic [IDX_W-1:0]     owner_q, owner_d;

    logic [NUM_MASTERS-1:0] req;
    logic                   arb_valid;
    logic [IDX_W-1:0]       arb_idx;
    int                     cand;
    logic [IDX_W-1:0]       cand_idx;
    logic                   sel_valid;
    logic [IDX_W-1:0]       sel_idx;
    logic [NUM_MASTERS-1:0] grant_oh;
    logic                   timeout;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout = (state_q == BUSY) && req[owner_q] && !ready_in && ce_i &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    // Rotating priority scan starting just after the last completed grantee.
    always_comb begin
        req       = m_read_in | m_write_in;
        arb_valid = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand     = (int'(last_grant_q) + k) % NUM_MASTERS;
            cand_idx = IDX_W'(cand);
            if (!arb_valid && req[cand_idx]) begin
                arb_valid = 1'b1;
                arb_idx   = cand_idx;
            end
        end
        sel_idx   = (state_q == BUSY) ? owner_q : arb_idx;
        sel_valid = (state_q == BUSY) ? req[owner_q] : arb_valid;
        grant_oh  = NUM_MASTERS'(1) << sel_idx;
    end

    always_comb begin
        m_read_value_out = reset_n ? read_value_in : '0;
        m_ready_out      = '0;
        m_fault_out      = '0;
        address_out      = '0;
        read_out         = 1'b0;
        write_out        = 1'b0;
        write_mask_out   = '0;
        write_value_out  = '0;
        grant_out        = '0;
        busy_out         = reset_n && (state_q == BUSY);
        if (reset_n && sel_valid) begin
            address_out     = m_address_in[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
            read_out        = m_read_in[sel_idx] && !timeout;
            write_out       = m_write_in[sel_idx] && !timeout;
            write_mask_out  = m_write_mask_in[sel_idx*MASK_W +: MASK_W];
            write_value_out = m_write_value_in[sel_idx*DATA_WIDTH +: DATA_WIDTH];
            grant_out       = grant_oh;
            m_ready_out     = grant_oh & {NUM_MASTERS{ready_in | timeout}};
            m_fault_out     = grant_oh & {NUM_MASTERS{(ready_in & fault_in) | timeout}};
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        if (ce_i) begin
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        if (ready_in) begin
                            last_grant_d = arb_idx;
                        end else begin
                            owner_d = arb_idx;
                            state_d = BUSY;
`ifdef BUS_ARBITER_TIMEOUT_EN
                            cnt_d   = '0;
`endif
                        end
                    end
                end
                BUSY: begin
                    // A grantee that withdraws abandons the transfer without earning the last_grant slot.
                    if (!req[owner_q]) begin
                        state_d = IDLE;
                    end else if (ready_in || timeout) begin
                        state_d      = IDLE;
                        last_grant_d = owner_q;
                    end else begin
`ifdef BUS_ARBITER_TIMEOUT_EN
                        cnt_d = cnt_q + CNT_W'(1);
`endif
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_MASTERS - 1);
            owner_q      <= '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
`ifdef BUS_ARBITER_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

endmodule
